lat_meter: RTL
==============

# lat_meter

Latency-measurement sequencer for the built-in lag tester. It sits directly upstream of the test-pattern video generator: it drives that generator's `lt_active`/`lt_mode` inputs and watches its VSYNC output to align each flash to a frame start. It times the interval until an external photodiode reports light, in microseconds. Results go to the CPU/OSD side through a registered result word and a one-cycle done strobe.

## Interface
- `SENSOR_FILT`, default 16: consecutive synchronized samples that must agree before a sensor level change is accepted (1..255).
- `TIMEOUT_US`, default 50000: measurement abandoned when the µs count reaches this value.
- `PRESC_DIV`, default 27: clk27 cycles per µs tick.

Ports:
- `clk27`  in  1  27 MHz pixel clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a measurement; ignored while `busy`.
- `abort`  in  1  synchronous abort; returns to IDLE with no `done`.
- `mode_in`  in  2  flash position (top-left / center / bottom-right), latched at `start`.
- `vsync_in`  in  1  video VSYNC, active-low, same clock domain.
- `sensor_in`  in  1  photodiode comparator, asynchronous, high = light.
- `lt_active`  out  1  flash enable to the video generator.
- `lt_mode`  out  2  latched flash position.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle strobe; result outputs are valid from this cycle on.
- `timeout`  out  1  last measurement timed out.
- `lat_us`  out  16  rise latency in µs (0xFFFF on timeout).
- `fall_us`  out  16  fall latency in µs; present only with the configuration macro, otherwise constant 0.

## Operation
- The sensor passes through a 2-FF synchronizer and then a filter. The filtered level changes only after `SENSOR_FILT` consecutive synchronized samples at the new value.
- State machine:
  - IDLE: `lt_active`=0. On `start`, latch `mode_in` into `lt_mode`, clear `timeout`, go to ARM.
  - ARM: wait for filtered sensor = 0 (dark), then go to WAIT_VS. If the sensor is still lit after `TIMEOUT_US` µs, go to timeout handling.
  - WAIT_VS: detect a falling edge of `vsync_in` (previous registered value 1, current value 0). On the edge, set `lt_active`=1, clear the prescaler and µs counter, and go to MEASURE.
  - MEASURE: a prescaler counts 0..PRESC_DIV-1; the µs counter increments when the prescaler reaches PRESC_DIV-1. When the filtered sensor rises: latch `lat_us` = µs count, set `lt_active`=0, clear the counters, go to RELEASE.
  - RELEASE: wait for filtered sensor = 0. With the configuration macro enabled, count µs and latch `fall_us` at this point. Then go to IDLE and pulse `done`.
- Timeout handling (any state other than IDLE, whenever the µs count equals `TIMEOUT_US`): `lat_us`=0xFFFF, `timeout`=1, `lt_active`=0, pulse `done`, go to IDLE.
- Counter arithmetic: the µs counter is 16 bits and saturates. It never wraps, because `TIMEOUT_US` must be ≤ 0xFFFE.
- `abort` takes priority over every other transition, including a simultaneous `start`. It forces IDLE and `lt_active`=0, and leaves result registers unchanged.
- `start` while `busy` has no effect.

## Timing
- Reset values: `lt_active` 0, `lt_mode` 0, `busy` 0, `done` 0, `timeout` 0, `lat_us` 0, `fall_us` 0. FSM state is IDLE; filter state is dark.
- `busy` rises the cycle after `start`.
- `lt_active` rises the cycle after the VSYNC falling edge is sampled.
- MEASURE cycle 0 is the first cycle with `lt_active`=1. After N cycles the µs count is floor(N/PRESC_DIV).
- The sensor path adds 2 (sync) + `SENSOR_FILT` cycles to the measured value. This offset is intentional and is not compensated.
- `done` is high for exactly one cycle, simultaneous with `busy` falling. `lat_us`/`fall_us`/`timeout` are updated no later than the `done` cycle.
- Reset asserted mid-measurement: all outputs take reset values immediately (asynchronous reset).

## Configuration
- `LAT_METER_FALL_EN` defined: RELEASE measures the fall time (from `lt_active` deassertion to the filtered sensor going dark) into `fall_us`. RELEASE is also subject to the timeout rule.
- Undefined: RELEASE only waits for dark with no counting; `fall_us` is constant 0 and the fall-counter logic is absent.

## Structure
- Shared package `lat_meter_pkg` holds:
  - FSM state encoding (IDLE, ARM, WAIT_VS, MEASURE, RELEASE);
  - the timeout sentinel 16'hFFFF;
  - the flash-position codes shared with the video generator.
- One sub-module, `sensor_filter`: 2-FF synchronizer plus `SENSOR_FILT` debounce counter. Its output is the filtered level plus one-cycle rise and fall pulses.

## Test plan
- Rise latency: `start`; VSYNC falls; sensor goes high 27000 cycles after `lt_active` rises; sensor drops 100 cycles after `lt_active` falls. Required: `lat_us` = floor((27000+18)/27) = 1000, `timeout`=0, `done` pulses once.
- Timeout: `start`, VSYNC runs normally, sensor held low. Required: `done` at µs count 50000 after MEASURE entry, `lat_us`=0xFFFF, `timeout`=1, `lt_active`=0.
- Sensor glitch: 10-cycle high pulses on `sensor_in` during MEASURE. Required: no detection; a later steady high is still detected correctly.
- Abort with simultaneous `start` during MEASURE. Required: IDLE next cycle, `lt_active`=0, no `done`, `lat_us` holds its previous value.
- Reset mid-MEASURE, then a new `start`. Required: outputs take reset values; the next measurement completes normally.
- `LAT_METER_FALL_EN` build: sensor goes dark 5400 cycles (+18 filter) after `lt_active` falls. Required: `fall_us` = 200. Default build: `fall_us` = 0.

Source files
------------

// File: rtl/lat_meter_pkg.sv
// Shared definitions for the lag-tester latency meter and the test-pattern generator it drives.
package lat_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_VS,
        ST_MEASURE,
        ST_RELEASE
    } state_t;

    // Result word reported for a timed-out measurement
    localparam logic [15:0] LAT_TIMEOUT = 16'hFFFF;

    // Flash position codes understood by the video generator
    localparam logic [1:0] POS_TOP_LEFT     = 2'd0;
    localparam logic [1:0] POS_CENTER       = 2'd1;
    localparam logic [1:0] POS_BOTTOM_RIGHT = 2'd2;

endpackage

// File: rtl/lat_meter_sensor_filter.sv
// Photodiode conditioning: 2-FF synchronizer followed by a SENSOR_FILT-sample debounce.
module sensor_filter #(
    parameter int SENSOR_FILT = 16
) (
    input  logic clk27,
    input  logic reset_n,
    input  logic sensor_in,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int            CW        = (SENSOR_FILT > 1) ? $clog2(SENSOR_FILT) : 1;
    localparam logic [CW-1:0] FILT_LAST = CW'(SENSOR_FILT - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] agree_cnt;

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            agree_cnt <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync_p0 <= sensor_in;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            // Any sample matching the current level restarts the run count
            if (sync_p1 == level) begin
                agree_cnt <= '0;
            end else if (agree_cnt == FILT_LAST) begin
                agree_cnt <= '0;
                level     <= sync_p1;
                rise      <= sync_p1;
                fall      <= ~sync_p1;
            end else begin
                agree_cnt <= agree_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/lat_meter.sv
// Lag-tester sequencer: flashes on a VSYNC edge and times the photodiode response in microseconds.
// Build with LAT_METER_FALL_EN defined to also measure the fall time into fall_us.
module lat_meter
    import lat_meter_pkg::*;
#(
    parameter int SENSOR_FILT = 16,
    parameter int TIMEOUT_US  = 50000,
    parameter int PRESC_DIV   = 27
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  mode_in,
    input  logic        vsync_in,
    input  logic        sensor_in,
    output logic        lt_active,
    output logic [1:0]  lt_mode,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] lat_us,
    output logic [15:0] fall_us
);
    localparam int            PW          = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(PRESC_DIV - 1);
    localparam logic [15:0]   TIMEOUT_CNT = 16'(TIMEOUT_US);
    localparam logic [15:0]   US_MAX      = 16'hFFFF;

    state_t        state;
    state_t        state_nxt;
    logic          sens_lvl;
    logic          sens_rise;
    logic          sens_fall;
    logic          vsync_prev;
    logic          vs_fall;
    logic [PW-1:0] presc;
    logic [15:0]   us_cnt;
    logic          cnt_clr;
    logic          cnt_run;
    logic          lt_active_nxt;
    logic [1:0]    lt_mode_nxt;
    logic          done_nxt;
    logic          timeout_nxt;
    logic [15:0]   lat_nxt;
`ifdef LAT_METER_FALL_EN
    logic [15:0]   fall_nxt;
`endif

    sensor_filter #(
        .SENSOR_FILT(SENSOR_FILT)
    ) u_sensor_filter (
        .clk27    (clk27),
        .reset_n  (reset_n),
        .sensor_in(sensor_in),
        .level    (sens_lvl),
        .rise     (sens_rise),
        .fall     (sens_fall)
    );

    assign vs_fall = vsync_prev & ~vsync_in;
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_nxt     = state;
        lt_active_nxt = lt_active;
        lt_mode_nxt   = lt_mode;
        done_nxt      = 1'b0;
        timeout_nxt   = timeout;
        lat_nxt       = lat_us;
        cnt_clr       = 1'b0;
        cnt_run       = 1'b0;
`ifdef LAT_METER_FALL_EN
        fall_nxt      = fall_us;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    lt_mode_nxt = mode_in;
                    timeout_nxt = 1'b0;
                    cnt_clr     = 1'b1;
                    state_nxt   = ST_ARM;
                end
            end
            ST_ARM: begin
                cnt_run = 1'b1;
                if (!sens_lvl) begin
                    state_nxt = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                cnt_run = 1'b1;
                if (vs_fall) begin
                    lt_active_nxt = 1'b1;
                    cnt_clr       = 1'b1;
                    state_nxt     = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                cnt_run = 1'b1;
                if (sens_rise) begin
                    lat_nxt       = us_cnt;
                    lt_active_nxt = 1'b0;
                    cnt_clr       = 1'b1;
                    state_nxt     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
`ifdef LAT_METER_FALL_EN
                cnt_run = 1'b1;
`endif
                // RELEASE is only entered right after a rise, so a fall pulse is guaranteed to follow
                if (sens_fall) begin
`ifdef LAT_METER_FALL_EN
                    fall_nxt = us_cnt;
`endif
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // The timeout applies exactly where the microsecond counter is running
        if (cnt_run && (us_cnt == TIMEOUT_CNT)) begin
            lat_nxt       = LAT_TIMEOUT;
            timeout_nxt   = 1'b1;
            lt_active_nxt = 1'b0;
            done_nxt      = 1'b1;
            state_nxt     = ST_IDLE;
        end

        if (abort) begin
            state_nxt     = ST_IDLE;
            lt_active_nxt = 1'b0;
            lt_mode_nxt   = lt_mode;
            done_nxt      = 1'b0;
            timeout_nxt   = timeout;
            lat_nxt       = lat_us;
`ifdef LAT_METER_FALL_EN
            fall_nxt      = fall_us;
`endif
        end
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            lt_active  <= 1'b0;
            lt_mode    <= POS_TOP_LEFT;
            done       <= 1'b0;
            timeout    <= 1'b0;
            lat_us     <= '0;
            vsync_prev <= 1'b0;
        end else begin
            lt_active  <= lt_active_nxt;
            lt_mode    <= lt_mode_nxt;
            done       <= done_nxt;
            timeout    <= timeout_nxt;
            lat_us     <= lat_nxt;
            vsync_prev <= vsync_in;
        end
    end

    // Prescaler plus saturating microsecond counter
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            presc  <= '0;
            us_cnt <= '0;
        end else if (cnt_clr) begin
            presc  <= '0;
            us_cnt <= '0;
        end else if (cnt_run) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                if (us_cnt != US_MAX) begin
                    us_cnt <= us_cnt + 16'd1;
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

`ifdef LAT_METER_FALL_EN
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            fall_us <= '0;
        end else begin
            fall_us <= fall_nxt;
        end
    end
`else
    assign fall_us = '0;
`endif

endmodule
